// File: rtl/sb_transactions_tx.sv
// USB4 sideband transaction transmitter: frames AT and LT transactions into
// 10-bit sideband symbols with DLE stuffing; CRC-16 insertion under SB_TX_CRC_EN.
module sb_transactions_tx #(
  parameter logic [15:0] CRC_INIT = 16'hFFFF,
  parameter logic [15:0] CRC_POLY = 16'h8005
) (
  input  logic        sb_clk,
  input  logic        rst,
  input  logic        tconnect,
  input  logic        tdisconnect,
  input  logic        at_start,
  input  logic        at_cmd,
  input  logic        at_write,
  input  logic [7:0]  at_address,
  input  logic [23:0] at_payload,
  input  logic        lt_start,
  input  logic [6:0]  lt_lse,
  output logic [9:0]  sbtx,
  output logic        sbtx_valid,
  output logic        busy,
  output logic        done,
  output logic        disconnected
);

  localparam logic [7:0] DLE     = 8'hFE;
  localparam logic [7:0] STX_CMD = 8'h05;
  localparam logic [7:0] STX_RSP = 8'h04;
  localparam logic [7:0] ETX     = 8'h40;

  typedef enum logic [3:0] {
    S_DISC,
    S_IDLE,
    S_LT_LSE,
    S_LT_CLSE,
    S_AT_STX,
    S_AT_ADDR,
    S_AT_RW,
    S_AT_DATA,
    S_AT_CRC,
    S_AT_DLE2,
    S_AT_ETX
  } state_e;

  state_e      state_q, state_d;
  state_e      hdr_end;
  logic        sof_q, sof_d;
  logic        stuff_q, stuff_d;
  logic [1:0]  idx_q, idx_d;
  logic        cmd_q, cmd_d;
  logic        wr_q, wr_d;
  logic [7:0]  addr_q, addr_d;
  logic [23:0] pay_q, pay_d;
  logic [6:0]  lse_q, lse_d;
  logic [9:0]  sbtx_q, sbtx_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        disc_q, disc_d;

  logic [7:0]  stx_b;
  logic [7:0]  rw_b;
  logic [7:0]  data_b;
  logic [7:0]  cur_b;
  logic [7:0]  ob;
  logic        has_data;
  logic        emit;
  logic        stuffed;

`ifdef SB_TX_CRC_EN
  logic [15:0] crc_q, crc_d;
  logic [7:0]  crc_b;

  function automatic logic [15:0] crc_upd(
    input logic [15:0] c,
    input logic [7:0]  b
  );
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ b[i]) r = {r[14:0], 1'b0} ^ CRC_POLY;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign crc_b   = idx_q[0] ? crc_q[7:0] : crc_q[15:8];
  assign hdr_end = S_AT_CRC;
`else
  assign hdr_end = S_AT_DLE2;
`endif

  assign has_data = wr_q | ~cmd_q;
  assign stx_b    = cmd_q ? STX_CMD : STX_RSP;
  assign rw_b     = {wr_q, has_data ? 7'd3 : 7'd0};

  always_comb begin
    data_b = pay_q[7:0];
    case (idx_q)
      2'd0:    data_b = pay_q[23:16];
      2'd1:    data_b = pay_q[15:8];
      default: data_b = pay_q[7:0];
    endcase
  end

  // Byte subject to DLE stuffing in the current state
  always_comb begin
    cur_b = DLE;
    case (state_q)
      S_AT_ADDR: cur_b = addr_q;
      S_AT_RW:   cur_b = rw_b;
      S_AT_DATA: cur_b = data_b;
`ifdef SB_TX_CRC_EN
      S_AT_CRC:  cur_b = crc_b;
`endif
      default:   cur_b = DLE;
    endcase
  end

  assign stuffed = (cur_b == DLE) && !stuff_q;

  always_comb begin
    state_d = state_q;
    sof_d   = sof_q;
    stuff_d = stuff_q;
    idx_d   = idx_q;
    cmd_d   = cmd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    pay_d   = pay_q;
    lse_d   = lse_q;
`ifdef SB_TX_CRC_EN
    crc_d   = crc_q;
`endif
    emit    = 1'b0;
    ob      = DLE;
    done_d  = 1'b0;

    case (state_q)
      S_DISC: begin
        if (tconnect && !tdisconnect) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (lt_start) begin
          lse_d   = lt_lse;
          sof_d   = 1'b1;
          state_d = S_LT_LSE;
        end else if (at_start) begin
          cmd_d   = at_cmd;
          wr_d    = at_write;
          addr_d  = at_address;
          pay_d   = at_payload;
          sof_d   = 1'b1;
          stuff_d = 1'b0;
          idx_d   = 2'd0;
`ifdef SB_TX_CRC_EN
          crc_d   = CRC_INIT;
`endif
          state_d = S_AT_STX;
        end
      end
      S_LT_LSE: begin
        emit = 1'b1;
        if (sof_q) begin
          sof_d = 1'b0;
        end else begin
          ob      = {1'b1, lse_q};
          state_d = S_LT_CLSE;
        end
      end
      S_LT_CLSE: begin
        emit    = 1'b1;
        ob      = ~{1'b1, lse_q};
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_AT_STX: begin
        emit = 1'b1;
        if (sof_q) begin
          sof_d = 1'b0;
        end else begin
          ob      = stx_b;
`ifdef SB_TX_CRC_EN
          crc_d   = crc_upd(crc_q, stx_b);
`endif
          state_d = S_AT_ADDR;
        end
      end
      S_AT_ADDR, S_AT_RW, S_AT_DATA: begin
        emit    = 1'b1;
        ob      = cur_b;
        stuff_d = stuffed;
`ifdef SB_TX_CRC_EN
        if (!stuff_q) crc_d = crc_upd(crc_q, cur_b);
`endif
        if (!stuffed) begin
          if (state_q == S_AT_ADDR) begin
            state_d = S_AT_RW;
          end else if (state_q == S_AT_RW) begin
            idx_d   = 2'd0;
            state_d = has_data ? S_AT_DATA : hdr_end;
          end else if (idx_q == 2'd2) begin
            idx_d   = 2'd0;
            state_d = hdr_end;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
`ifdef SB_TX_CRC_EN
      S_AT_CRC: begin
        emit    = 1'b1;
        ob      = cur_b;
        stuff_d = stuffed;
        if (!stuffed) begin
          if (idx_q[0]) begin
            idx_d   = 2'd0;
            state_d = S_AT_DLE2;
          end else begin
            idx_d = 2'd1;
          end
        end
      end
`endif
      S_AT_DLE2: begin
        emit    = 1'b1;
        state_d = S_AT_ETX;
      end
      S_AT_ETX: begin
        emit    = 1'b1;
        ob      = ETX;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_DISC;
    endcase

    // Disconnect truncates whatever is in flight
    if (tdisconnect && state_q != S_DISC) begin
      state_d = S_DISC;
      emit    = 1'b0;
      done_d  = 1'b0;
      sof_d   = 1'b0;
      stuff_d = 1'b0;
      idx_d   = 2'd0;
    end

    sbtx_d  = emit ? {1'b1, ob, 1'b0} : 10'h3FF;
    valid_d = emit;
    busy_d  = emit;
    disc_d  = (state_d == S_DISC);
  end

  always_ff @(posedge sb_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_DISC;
      sof_q   <= 1'b0;
      stuff_q <= 1'b0;
      idx_q   <= 2'd0;
      cmd_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 8'h00;
      pay_q   <= 24'h0;
      lse_q   <= 7'h00;
`ifdef SB_TX_CRC_EN
      crc_q   <= CRC_INIT;
`endif
      sbtx_q  <= 10'h3FF;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      disc_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      sof_q   <= sof_d;
      stuff_q <= stuff_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      pay_q   <= pay_d;
      lse_q   <= lse_d;
`ifdef SB_TX_CRC_EN
      crc_q   <= crc_d;
`endif
      sbtx_q  <= sbtx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      disc_q  <= disc_d;
    end
  end

  assign sbtx         = sbtx_q;
  assign sbtx_valid   = valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign disconnected = disc_q;

endmodule

// File: tb/tb_sb_transactions_tx.sv
// Bench for sb_transactions_tx: table vectors, random frames against a
// byte-list reference model, and disconnect/reset corner sequences.
module tb_sb_transactions_tx;

`ifdef SB_TX_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic        lt;
    logic [6:0]  lse;
    logic        cmd;
    logic        wr;
    logic [7:0]  addr;
    logic [23:0] pay;
  } req_t;

  typedef struct {
    req_t        r;
    int          len;
    logic [31:0] head;
  } vec_t;

  logic        sb_clk = 1'b0;
  logic        rst;
  logic        tconnect;
  logic        tdisconnect;
  logic        at_start;
  logic        at_cmd;
  logic        at_write;
  logic [7:0]  at_address;
  logic [23:0] at_payload;
  logic        lt_start;
  logic [6:0]  lt_lse;
  logic [9:0]  sbtx;
  logic        sbtx_valid;
  logic        busy;
  logic        done;
  logic        disconnected;

  int tests = 0;
  int fails = 0;

  sb_transactions_tx dut (
    .sb_clk      (sb_clk),
    .rst         (rst),
    .tconnect    (tconnect),
    .tdisconnect (tdisconnect),
    .at_start    (at_start),
    .at_cmd      (at_cmd),
    .at_write    (at_write),
    .at_address  (at_address),
    .at_payload  (at_payload),
    .lt_start    (lt_start),
    .lt_lse      (lt_lse),
    .sbtx        (sbtx),
    .sbtx_valid  (sbtx_valid),
    .busy        (busy),
    .done        (done),
    .disconnected(disconnected)
  );

  always #5 sb_clk = ~sb_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic string q2s(input bq_t q);
    string s;
    s = "";
    foreach (q[k]) s = {s, $sformatf("%02h ", q[k])};
    return s;
  endfunction

  // CRC as remainder of long division of the augmented message
  function automatic logic [15:0] crc_ref(input bq_t msg);
    bit          bits[$];
    logic [16:0] rem;
    logic [15:0] seed;
    logic [16:0] gen;
    seed = 16'hFFFF;
    gen  = 17'h18005;
    rem  = '0;
    foreach (msg[k])
      for (int j = 7; j >= 0; j--) bits.push_back(msg[k][j]);
    for (int i = 0; i < 16; i++) bits[i] = bits[i] ^ seed[15-i];
    repeat (16) bits.push_back(1'b0);
    foreach (bits[k]) begin
      rem = {rem[15:0], bits[k]};
      if (rem[16]) rem = rem ^ gen;
    end
    return rem[15:0];
  endfunction

  task automatic build_exp(input req_t r, output bq_t q, output int ncrc);
    bq_t         msg;
    logic [7:0]  b;
    logic [15:0] c;
    logic        dp;
    q = {};
    ncrc = 0;
    if (r.lt) begin
      b = {1'b1, r.lse};
      q.push_back(8'hFE);
      q.push_back(b);
      q.push_back(~b);
      return;
    end
    dp = r.wr | ~r.cmd;
    msg.push_back(r.cmd ? 8'h05 : 8'h04);
    msg.push_back(r.addr);
    msg.push_back({r.wr, dp ? 7'd3 : 7'd0});
    if (dp) begin
      msg.push_back(r.pay[23:16]);
      msg.push_back(r.pay[15:8]);
      msg.push_back(r.pay[7:0]);
    end
    q.push_back(8'hFE);
    q.push_back(msg[0]);
    for (int k = 1; k < msg.size(); k++) begin
      q.push_back(msg[k]);
      if (msg[k] == 8'hFE) q.push_back(8'hFE);
    end
    if (CRC_ON) begin
      c = crc_ref(msg);
      for (int h = 1; h >= 0; h--) begin
        b = h[0] ? c[15:8] : c[7:0];
        q.push_back(b);
        ncrc++;
        if (b == 8'hFE) begin
          q.push_back(8'hFE);
          ncrc++;
        end
      end
    end
    q.push_back(8'hFE);
    q.push_back(8'h40);
  endtask

  task automatic do_frame(input req_t r, input bit both, input int inj,
                          input int exp_len, input logic [31:0] head,
                          input string nm);
    bq_t         exp;
    bq_t         got;
    int          ncrc;
    int          n;
    int          dcnt;
    int          dpos;
    bit          fmt_ok;
    bit          ok;
    logic [31:0] gh;
    logic [31:0] eh;
    build_exp(r, exp, ncrc);
    lt_lse     = r.lse;
    at_cmd     = r.cmd;
    at_write   = r.wr;
    at_address = r.addr;
    at_payload = r.pay;
    lt_start   = r.lt;
    at_start   = r.lt ? both : 1'b1;
    @(negedge sb_clk);
    lt_start   = 1'b0;
    at_start   = 1'b0;
    at_address = 8'($urandom);
    at_payload = 24'($urandom);
    lt_lse     = 7'($urandom);
    at_cmd     = 1'($urandom);
    at_write   = 1'($urandom);
    chk({nm, ":lat"}, 64'({sbtx_valid, busy}), 64'(2'b00));
    @(negedge sb_clk);
    n = 0;
    dcnt = 0;
    dpos = -1;
    fmt_ok = 1'b1;
    while (sbtx_valid === 1'b1 && n < 64) begin
      got.push_back(sbtx[8:1]);
      if (sbtx[9] !== 1'b1 || sbtx[0] !== 1'b0 || busy !== 1'b1)
        fmt_ok = 1'b0;
      if (done === 1'b1) begin
        dcnt++;
        dpos = n;
      end
      at_start = (n == inj);
      n++;
      @(negedge sb_clk);
    end
    at_start = 1'b0;
    ok = (got.size() == exp.size());
    if (ok) foreach (exp[k]) if (got[k] !== exp[k]) ok = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s:bytes got %s expected %s", nm, q2s(got), q2s(exp));
    end
    chk({nm, ":done"}, {dcnt, dpos}, {32'sd1, n - 1});
    chk({nm, ":fmt"}, 64'({fmt_ok, busy, done}), 64'(3'b100));
    if (exp_len >= 0) begin
      chk({nm, ":len"}, 64'(got.size()), 64'(exp_len + ncrc));
      gh = '0;
      eh = '0;
      for (int k = 0; k < 4 && k < exp_len; k++) begin
        eh[31-8*k -: 8] = head[31-8*k -: 8];
        gh[31-8*k -: 8] = (k < got.size()) ? got[k] : 8'h00;
      end
      chk({nm, ":head"}, 64'(gh), 64'(eh));
    end
  endtask

  task automatic idle_window(input int n, input string nm);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge sb_clk);
      if (sbtx_valid !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    chk(nm, 64'(seen), 64'(1'b0));
  endtask

  task automatic connect(input string nm);
    tconnect = 1'b1;
    @(negedge sb_clk);
    tconnect = 1'b0;
    chk(nm, 64'(disconnected), 64'(1'b0));
  endtask

  function automatic logic [7:0] rb();
    return ($urandom_range(0, 2) == 0) ? 8'hFE : 8'($urandom);
  endfunction

  vec_t vt[9];
  bit   dn;

  initial begin
    vt[0] = '{'{1'b1, 7'h05, 1'b0, 1'b0, 8'h00, 24'h000000}, 3, 32'hFE857A00};
    vt[1] = '{'{1'b1, 7'h7F, 1'b0, 1'b0, 8'h00, 24'h000000}, 3, 32'hFEFF0000};
    vt[2] = '{'{1'b1, 7'h7E, 1'b0, 1'b0, 8'h00, 24'h000000}, 3, 32'hFEFE0100};
    vt[3] = '{'{1'b0, 7'h00, 1'b1, 1'b0, 8'h12, 24'h000000}, 6, 32'hFE051200};
    vt[4] = '{'{1'b0, 7'h00, 1'b1, 1'b1, 8'hFE, 24'hFE0001}, 11, 32'hFE05FEFE};
    vt[5] = '{'{1'b0, 7'h00, 1'b0, 1'b0, 8'h34, 24'h123456}, 9, 32'hFE043403};
    vt[6] = '{'{1'b0, 7'h00, 1'b0, 1'b1, 8'hFE, 24'hFEFEFE}, 13, 32'hFE04FEFE};
    vt[7] = '{'{1'b0, 7'h00, 1'b1, 1'b1, 8'h00, 24'h000000}, 9, 32'hFE050083};
    vt[8] = '{'{1'b0, 7'h00, 1'b1, 1'b0, 8'hFF, 24'hABCDEF}, 6, 32'hFE05FF00};

    rst = 1'b1;
    tconnect = 1'b0;
    tdisconnect = 1'b0;
    at_start = 1'b0;
    at_cmd = 1'b0;
    at_write = 1'b0;
    at_address = 8'h00;
    at_payload = 24'h0;
    lt_start = 1'b0;
    lt_lse = 7'h00;
    repeat (2) @(negedge sb_clk);
    chk("reset", 64'({sbtx, sbtx_valid, busy, done, disconnected}),
        64'({10'h3FF, 1'b0, 1'b0, 1'b0, 1'b1}));
    rst = 1'b0;
    @(negedge sb_clk);
    chk("disc_hold", 64'({disconnected, sbtx_valid}), 64'(2'b10));

    lt_start = 1'b1;
    at_start = 1'b1;
    @(negedge sb_clk);
    lt_start = 1'b0;
    at_start = 1'b0;
    idle_window(8, "disc_ignore");
    connect("connect");

    for (int i = 0; i < 9; i++)
      do_frame(vt[i].r, 1'b0, -1, vt[i].len, vt[i].head,
               $sformatf("vec%0d", i));

    do_frame(vt[0].r, 1'b1, -1, 3, 32'hFE857A00, "lt_prio");
    idle_window(15, "lt_prio_noat");
    do_frame(vt[3].r, 1'b0, 2, 6, 32'hFE051200, "busy_ign");
    idle_window(15, "busy_noframe");

    for (int i = 0; i < 40; i++) begin
      req_t r;
      r.lt   = ($urandom_range(0, 2) == 0);
      r.lse  = ($urandom_range(0, 3) == 0) ? 7'h7E : 7'($urandom);
      r.cmd  = 1'($urandom);
      r.wr   = 1'($urandom);
      r.addr = rb();
      r.pay  = {rb(), rb(), rb()};
      do_frame(r, 1'b0, -1, -1, 32'h0, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) @(negedge sb_clk);
    end

    at_cmd = 1'b1;
    at_write = 1'b0;
    at_address = 8'h12;
    at_start = 1'b1;
    @(negedge sb_clk);
    at_start = 1'b0;
    @(negedge sb_clk);
    dn = done;
    repeat (3) begin
      @(negedge sb_clk);
      dn = dn | done;
    end
    chk("disc_sym4", 64'({sbtx_valid, sbtx[8:1]}), 64'({1'b1, 8'h00}));
    tdisconnect = 1'b1;
    @(negedge sb_clk);
    dn = dn | done;
    @(negedge sb_clk);
    dn = dn | done;
    chk("disc_out", 64'({sbtx_valid, disconnected, busy}), 64'(3'b010));
    chk("disc_nodone", 64'(dn), 64'(1'b0));
    tconnect = 1'b1;
    repeat (3) @(negedge sb_clk);
    chk("disc_both", 64'({disconnected, sbtx_valid}), 64'(2'b10));
    tdisconnect = 1'b0;
    @(negedge sb_clk);
    tconnect = 1'b0;
    chk("reconnect", 64'(disconnected), 64'(1'b0));
    do_frame(vt[4].r, 1'b0, -1, 11, 32'hFE05FEFE, "post_disc");

    at_cmd = 1'b0;
    at_write = 1'b1;
    at_address = 8'h55;
    at_start = 1'b1;
    @(negedge sb_clk);
    at_start = 1'b0;
    repeat (2) @(negedge sb_clk);
    chk("pre_rst", 64'(sbtx_valid), 64'(1'b1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst", 64'({sbtx, sbtx_valid, busy, done, disconnected}),
        64'({10'h3FF, 1'b0, 1'b0, 1'b0, 1'b1}));
    @(negedge sb_clk);
    rst = 1'b0;
    @(negedge sb_clk);
    chk("post_rst", 64'({disconnected, sbtx_valid}), 64'(2'b10));
    connect("reconnect2");
    do_frame(vt[2].r, 1'b0, -1, 3, 32'hFEFE0100, "post_rst_lt");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
